vld_pipe_credit_ctrl: RTL
=========================

// Module: vld_pipe_credit_ctrl
// PURPOSE
//  Admission controller for a fixed-latency, non-stallable datapath: a LATENCY-deep valid delay line feeding an output buffer of FIFO_DEPTH entries.
//  Issues a token into the pipe only when a buffer slot is guaranteed at arrival, so the buffer never overflows.
//  Counts in-flight and buffered tokens and supports enable/flush sequencing.
//  Sits between an upstream valid/ready source and the delay-line datapath plus its output FIFO.
// PARAMETERS
//  LATENCY     32   cycles from issue to pipe_vld_out (>=1)
//  FIFO_DEPTH  64   output buffer entries (>=1)
//  CNT_W       $clog2(FIFO_DEPTH+LATENCY+1)   counter width (derived, not overridden)
// PORTS
//  clk            in   1      single clock, posedge
//  rst            in   1      asynchronous, active-high reset
//  enable         in   1      level; allows admission
//  flush          in   1      pulse; stop admission and drain the pipe
//  s_valid        in   1      upstream token offered
//  s_ready        out  1      token accepted this cycle when s_valid=1
//  pipe_en        out  1      issue strobe into datapath (= s_valid & s_ready)
//  pipe_vld_out   out  1      token leaves pipe, written to buffer this cycle
//  fifo_pop       in   1      downstream consumer pops one buffer entry
//  credits        out  CNT_W  FIFO_DEPTH - occ - inflight
//  inflight       out  CNT_W  tokens issued but not yet out of the pipe
//  occ            out  CNT_W  buffer occupancy
//  drain_done     out  1      one-cycle pulse, DRAIN->IDLE
//  err_underflow  out  1      sticky; fifo_pop seen with occ=0
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): all delay-line stages 0, inflight=occ=0, credits=FIFO_DEPTH, state IDLE, all strobes 0, err_underflow=0.
//    Reset mid-operation discards all in-flight tokens.
//  - FSM IDLE/RUN/DRAIN, registered.
//    IDLE: enable=1 -> RUN.
//    RUN: flush=1 -> DRAIN (flush wins over enable); enable=0 -> IDLE.
//    DRAIN: inflight=0 and no pipe_en this cycle -> IDLE with drain_done=1.
//    flush in IDLE/DRAIN is ignored.
//  - s_ready = (state==RUN) & (credits!=0). It depends only on registered values, never on s_valid (no comb loop).
//    s_ready falls in the cycle the flush is sampled + 1.
//  - Delay line: pipe_vld_out = pipe_en delayed exactly LATENCY cycles. It is always shifting; there is no stall.
//  - inflight: +1 on pipe_en, -1 on pipe_vld_out; both in the same cycle -> unchanged.
//  - occ: +1 on pipe_vld_out, -1 on accepted pop; both in the same cycle -> unchanged.
//  - Pop with occ=0: ignored (occ stays 0) and err_underflow set until rst.
//  - Invariant: occ+inflight <= FIFO_DEPTH always. Counters never wrap.
//  - credits/inflight/occ are registered; they update the cycle after the event.
//  - The buffer keeps draining via fifo_pop in every state.
// STRUCTURE
//  - Shared package vld_pkg: FSM state enum (ST_IDLE, ST_RUN, ST_DRAIN) and the CNT_W width function.
//  - One sub-module: vld_dly_line (LATENCY-stage 1-bit shift register with async reset, always enabled).
//    It produces pipe_vld_out from pipe_en.
//  - Counters, FSM and s_ready logic live in the top module.
// TESTING
//  1. rst, enable=1, s_valid=1 continuous, no pops, LATENCY=4, FIFO_DEPTH=8
//     -> exactly 8 pipe_en pulses then s_ready=0; pipe_vld_out from cycle 4 after the first issue; occ ends at 8, inflight at 0.
//  2. Steady state, fifo_pop=1 every cycle, s_valid=1
//     -> one issue per cycle sustained; occ constant; credits never 0 after fill.
//  3. Flush with inflight=3
//     -> s_ready=0 next cycle; three pipe_vld_out pulses; drain_done one pulse when inflight reaches 0; state IDLE.
//  4. fifo_pop with occ=0
//     -> occ stays 0; err_underflow=1 and held until rst.
//  5. rst asserted mid-stream with inflight=5
//     -> all outputs immediately at reset values; no pipe_vld_out after release.
//  6. Issue and retire in the same cycle, and pop and arrive in the same cycle -> inflight and occ unchanged.

Source files
------------

// File: rtl/vld_pkg.sv
// Shared types and helpers for the valid-pipe credit controller.
package vld_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Counter width large enough to hold every token the pipe plus buffer can own.
    function automatic int cnt_w(input int depth, input int latency);
        return $clog2(depth + latency + 1);
    endfunction

endpackage

// File: rtl/vld_dly_line.sv
// Fixed-latency valid delay line: dout is din delayed exactly LATENCY cycles.
module vld_dly_line #(
    parameter int LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [LATENCY-1:0] sr;

    // Free-running shift register; the datapath cannot stall, so neither can this.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | LATENCY'(din);
        end
    end

    assign dout = sr[LATENCY-1];

endmodule

// File: rtl/vld_pipe_credit_ctrl.sv
// Admission controller for a non-stallable LATENCY-deep pipe feeding a
// FIFO_DEPTH-entry buffer. A token is issued only when a buffer slot is
// reserved for it, so the buffer can never overflow.
module vld_pipe_credit_ctrl
    import vld_pkg::*;
#(
    parameter  int LATENCY    = 32,
    parameter  int FIFO_DEPTH = 64,
    localparam int CNT_W      = cnt_w(FIFO_DEPTH, LATENCY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             pipe_en,
    output logic             pipe_vld_out,
    input  logic             fifo_pop,
    output logic [CNT_W-1:0] credits,
    output logic [CNT_W-1:0] inflight,
    output logic [CNT_W-1:0] occ,
    output logic             drain_done,
    output logic             err_underflow
);

    state_e state_q;
    state_e state_d;
    logic   pop_ok;

    // Ready depends only on registered state so upstream never sees a comb loop.
    assign s_ready = (state_q == ST_RUN) && (credits != '0);
    assign pipe_en = s_valid && s_ready;
    assign pop_ok  = fifo_pop && (occ != '0);

    vld_dly_line #(
        .LATENCY(LATENCY)
    ) u_dly_line (
        .clk (clk),
        .rst (rst),
        .din (pipe_en),
        .dout(pipe_vld_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; flush outranks enable while running.
    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if ((inflight == '0) && !pipe_en) begin
                    state_d    = ST_IDLE;
                    drain_done = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // In-flight count: issue adds, pipe exit removes, both together cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (pipe_en && !pipe_vld_out) begin
            inflight <= inflight + CNT_W'(1);
        end else if (!pipe_en && pipe_vld_out) begin
            inflight <= inflight - CNT_W'(1);
        end
    end

    // Buffer occupancy: arrival adds, accepted pop removes, both together cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (pipe_vld_out && !pop_ok) begin
            occ <= occ + CNT_W'(1);
        end else if (!pipe_vld_out && pop_ok) begin
            occ <= occ - CNT_W'(1);
        end
    end

    // Credits are consumed at issue and returned at pop; a token moving from pipe to buffer keeps its credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CNT_W'(FIFO_DEPTH);
        end else if (pipe_en && !pop_ok) begin
            credits <= credits - CNT_W'(1);
        end else if (!pipe_en && pop_ok) begin
            credits <= credits + CNT_W'(1);
        end
    end

    // Sticky flag for a pop attempted against an empty buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (fifo_pop && (occ == '0)) begin
            err_underflow <= 1'b1;
        end
    end

endmodule
